// File: rtl/hold_detect_pkg.sv
// Shared types and helpers for the multi-channel hold detector.
// Holds the per-channel FSM state encoding and a width-generic saturating increment.
package hold_detect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HELD  = 2'd2
    } state_e;

    localparam int unsigned SAT_MAX_W = 32;

    // Increment val, clamping at the all-ones value of a width-bit counter.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] val,
                                                     input int unsigned            width);
        logic [SAT_MAX_W-1:0] lim;
        lim = (width >= SAT_MAX_W) ? '1
                                   : ((SAT_MAX_W'(1) << width) - SAT_MAX_W'(1));
        sat_inc = (val >= lim) ? lim : (val + SAT_MAX_W'(1));
    endfunction

endpackage

// File: rtl/hold_detect_chan.sv
// One hold-detect channel: saturating run-length counter, IDLE/COUNT/HELD FSM
// and the detect / detect_pulse flags, all registered.
module hold_detect_chan
    import hold_detect_pkg::*;
#(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_lvl,
    input  logic [CNT_W-1:0] thresh,
    input  logic             sticky_en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             detect,
    output logic             detect_pulse
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             det_q, det_d;
    logic             pulse_q, pulse_d;
    logic             hit;
    logic             set;

    // Next-state: a run that reaches thresh on its first edge goes straight to HELD.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        det_d   = det_q;
        pulse_d = 1'b0;
        hit     = 1'b0;
        set     = 1'b0;

        if (in_lvl) begin
            cnt_d = CNT_W'(sat_inc(SAT_MAX_W'(cnt_q), CNT_W));
        end
        hit = in_lvl && (thresh != '0) && (cnt_d >= thresh);

        case (state_q)
            ST_IDLE:  if (in_lvl) state_d = hit ? ST_HELD : ST_COUNT;
            ST_COUNT: begin
                if (!in_lvl)  state_d = ST_IDLE;
                else if (hit) state_d = ST_HELD;
            end
            ST_HELD:  if (!in_lvl) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        set = (state_q != ST_HELD) && (state_d == ST_HELD);

        // A new detection beats a coincident clr.
        if (set) begin
            det_d = 1'b1;
        end else if (clr) begin
            det_d = 1'b0;
        end else if ((state_q == ST_HELD) && (state_d != ST_HELD) && !sticky_en) begin
            det_d = 1'b0;
        end
        pulse_d = set;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            det_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            det_q   <= det_d;
            pulse_q <= pulse_d;
        end
    end

    assign count        = cnt_q;
    assign detect       = det_q;
    assign detect_pulse = pulse_q;

endmodule

// File: rtl/hold_detect_mc.sv
// Multi-channel hold detector: CHANNELS independent channels sharing
// thresh and sticky_en, with count packed CNT_W bits per channel.
module hold_detect_mc
    import hold_detect_pkg::*;
#(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CNT_W    = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_lvl,
    input  logic [CNT_W-1:0]          thresh,
    input  logic                      sticky_en,
    input  logic [CHANNELS-1:0]       clr,
    output logic [CHANNELS*CNT_W-1:0] count,
    output logic [CHANNELS-1:0]       detect,
    output logic [CHANNELS-1:0]       detect_pulse
);

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_chan
        hold_detect_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_lvl      (in_lvl[i]),
            .thresh      (thresh),
            .sticky_en   (sticky_en),
            .clr         (clr[i]),
            .count       (count[i*CNT_W +: CNT_W]),
            .detect      (detect[i]),
            .detect_pulse(detect_pulse[i])
        );
    end

endmodule

// File: tb/tb_hold_detect_mc.sv
// Scoreboard bench for hold_detect_mc: each scenario pushes the expected
// outputs for an edge, clocks it, then pops and compares.
module tb_hold_detect_mc;

    localparam int unsigned CH = 2;
    localparam int unsigned CW = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CH-1:0]    in_lvl;
    logic [CW-1:0]    thresh;
    logic             sticky_en;
    logic [CH-1:0]    clr;
    logic [CH*CW-1:0] count;
    logic [CH-1:0]    detect;
    logic [CH-1:0]    detect_pulse;

    typedef struct {
        string            name;
        int               edge_no;
        logic [CH*CW-1:0] cnt;
        logic [CH-1:0]    det;
        logic [CH-1:0]    pls;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    hold_detect_mc #(.CHANNELS(CH), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_lvl      (in_lvl),
        .thresh      (thresh),
        .sticky_en   (sticky_en),
        .clr         (clr),
        .count       (count),
        .detect      (detect),
        .detect_pulse(detect_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [CH*CW-1:0] pk(input int c1, input int c0);
        return {CW'(c1), CW'(c0)};
    endfunction

    function automatic exp_t mk(input string n, input int ed, input logic [CH*CW-1:0] c,
                                input logic [CH-1:0] d, input logic [CH-1:0] p);
        exp_t r;
        r.name = n; r.edge_no = ed; r.cnt = c; r.det = d; r.pls = p;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cleanup();
        in_lvl = '0; clr = '1; tick(); clr = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_lvl = 2'b11; clr = '0; thresh = 5'd1; sticky_en = 1'b1;
        sb.push_back(mk("reset", 0, '0, 2'b00, 2'b00));
        tick();
        e = sb.pop_front(); n_tests++;
        if ({count, detect, detect_pulse} !== {e.cnt, e.det, e.pls}) begin
            n_fail++;
            $display("FAIL %s edge %0d: got count=%h det=%b pls=%b, want count=%h det=%b pls=%b",
                     e.name, e.edge_no, count, detect, detect_pulse, e.cnt, e.det, e.pls);
        end
        rst_n = 1'b1; in_lvl = '0; tick();
    endtask

    task automatic test_basic();
        thresh = 5'd8; sticky_en = 1'b0;
        for (int ed = 1; ed <= 11; ed++) begin
            in_lvl = (ed <= 10) ? 2'b01 : 2'b00;
            if (ed <= 10) sb.push_back(mk("basic", ed, pk(0, ed), {1'b0, ed >= 8}, {1'b0, ed == 8}));
            else          sb.push_back(mk("basic_release", ed, pk(0, 0), 2'b00, 2'b00));
            tick();
            e = sb.pop_front(); n_tests++;
            if ({count, detect, detect_pulse} !== {e.cnt, e.det, e.pls}) begin
                n_fail++;
                $display("FAIL %s edge %0d: got count=%h det=%b pls=%b, want count=%h det=%b pls=%b",
                         e.name, e.edge_no, count, detect, detect_pulse, e.cnt, e.det, e.pls);
            end
        end
        cleanup();
    endtask

    task automatic test_sticky();
        thresh = 5'd3; sticky_en = 1'b1;
        for (int ed = 1; ed <= 8; ed++) begin
            in_lvl = (ed <= 4) ? 2'b10 : 2'b00;
            clr    = (ed == 7) ? 2'b10 : 2'b00;
            if (ed <= 4)      sb.push_back(mk("sticky_run", ed, pk(ed, 0), {ed >= 3, 1'b0}, {ed == 3, 1'b0}));
            else if (ed <= 6) sb.push_back(mk("sticky_hold", ed, pk(0, 0), 2'b10, 2'b00));
            else              sb.push_back(mk("sticky_clr", ed, pk(0, 0), 2'b00, 2'b00));
            tick();
            e = sb.pop_front(); n_tests++;
            if ({count, detect, detect_pulse} !== {e.cnt, e.det, e.pls}) begin
                n_fail++;
                $display("FAIL %s edge %0d: got count=%h det=%b pls=%b, want count=%h det=%b pls=%b",
                         e.name, e.edge_no, count, detect, detect_pulse, e.cnt, e.det, e.pls);
            end
        end
        cleanup();
    endtask

    task automatic test_saturate();
        int pulses = 0;
        thresh = 5'd31; sticky_en = 1'b0; in_lvl = 2'b01;
        for (int ed = 1; ed <= 40; ed++) begin
            sb.push_back(mk("saturate", ed, pk(0, (ed > 31) ? 31 : ed), {1'b0, ed >= 31}, {1'b0, ed == 31}));
            tick();
            pulses += int'(detect_pulse[0]);
            e = sb.pop_front(); n_tests++;
            if ({count, detect, detect_pulse} !== {e.cnt, e.det, e.pls}) begin
                n_fail++;
                $display("FAIL %s edge %0d: got count=%h det=%b pls=%b, want count=%h det=%b pls=%b",
                         e.name, e.edge_no, count, detect, detect_pulse, e.cnt, e.det, e.pls);
            end
        end
        n_tests++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL saturate_pulse_count: got %0d pulses, want 1", pulses);
        end
        cleanup();
    endtask

    task automatic test_clr_collide();
        logic [CH-1:0] d, p;
        thresh = 5'd4; sticky_en = 1'b1;
        for (int ed = 1; ed <= 14; ed++) begin
            in_lvl = (ed == 10) ? 2'b00 : 2'b01;
            clr    = (ed == 4 || ed == 6) ? 2'b01 : 2'b00;
            d = {1'b0, (ed >= 4 && ed <= 5) || ed == 14};
            p = {1'b0, ed == 4 || ed == 14};
            if (ed <= 9)       sb.push_back(mk("clr_collide", ed, pk(0, ed), d, p));
            else if (ed == 10) sb.push_back(mk("clr_release", ed, pk(0, 0), d, p));
            else               sb.push_back(mk("clr_new_run", ed, pk(0, ed - 10), d, p));
            tick();
            e = sb.pop_front(); n_tests++;
            if ({count, detect, detect_pulse} !== {e.cnt, e.det, e.pls}) begin
                n_fail++;
                $display("FAIL %s edge %0d: got count=%h det=%b pls=%b, want count=%h det=%b pls=%b",
                         e.name, e.edge_no, count, detect, detect_pulse, e.cnt, e.det, e.pls);
            end
        end
        clr = '0;
        cleanup();
    endtask

    task automatic test_reset_mid();
        thresh = 5'd20; sticky_en = 1'b0; in_lvl = 2'b11;
        for (int ed = 1; ed <= 8; ed++) begin
            rst_n = (ed == 6) ? 1'b0 : 1'b1;
            if (ed <= 5)       sb.push_back(mk("mid_count", ed, pk(ed, ed), 2'b00, 2'b00));
            else if (ed == 6)  sb.push_back(mk("mid_reset", ed, pk(0, 0), 2'b00, 2'b00));
            else               sb.push_back(mk("mid_restart", ed, pk(ed - 6, ed - 6), 2'b00, 2'b00));
            tick();
            e = sb.pop_front(); n_tests++;
            if ({count, detect, detect_pulse} !== {e.cnt, e.det, e.pls}) begin
                n_fail++;
                $display("FAIL %s edge %0d: got count=%h det=%b pls=%b, want count=%h det=%b pls=%b",
                         e.name, e.edge_no, count, detect, detect_pulse, e.cnt, e.det, e.pls);
            end
        end
        rst_n = 1'b1;
        cleanup();
    endtask

    task automatic test_thresh_zero();
        thresh = 5'd0; sticky_en = 1'b0; in_lvl = 2'b01;
        for (int ed = 1; ed <= 20; ed++) begin
            sb.push_back(mk("thresh_zero", ed, pk(0, ed), 2'b00, 2'b00));
            tick();
            e = sb.pop_front(); n_tests++;
            if ({count, detect, detect_pulse} !== {e.cnt, e.det, e.pls}) begin
                n_fail++;
                $display("FAIL %s edge %0d: got count=%h det=%b pls=%b, want count=%h det=%b pls=%b",
                         e.name, e.edge_no, count, detect, detect_pulse, e.cnt, e.det, e.pls);
            end
        end
        cleanup();
    endtask

    task automatic test_live_thresh();
        sticky_en = 1'b0;
        for (int ed = 1; ed <= 8; ed++) begin
            thresh = (ed <= 5) ? 5'd10 : 5'd3;
            in_lvl = (ed <= 7) ? 2'b01 : 2'b00;
            if (ed <= 7) sb.push_back(mk("live_thresh", ed, pk(0, ed), {1'b0, ed >= 6}, {1'b0, ed == 6}));
            else         sb.push_back(mk("live_release", ed, pk(0, 0), 2'b00, 2'b00));
            tick();
            e = sb.pop_front(); n_tests++;
            if ({count, detect, detect_pulse} !== {e.cnt, e.det, e.pls}) begin
                n_fail++;
                $display("FAIL %s edge %0d: got count=%h det=%b pls=%b, want count=%h det=%b pls=%b",
                         e.name, e.edge_no, count, detect, detect_pulse, e.cnt, e.det, e.pls);
            end
        end
        cleanup();
    endtask

    initial begin
        rst_n = 1'b0; in_lvl = '0; clr = '0; thresh = '0; sticky_en = 1'b0;
        test_reset();
        test_basic();
        test_sticky();
        test_saturate();
        test_clr_collide();
        test_reset_mid();
        test_thresh_zero();
        test_live_thresh();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
